// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
package mdu_pkg;

  // funct3 encodings of the M-extension instructions
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // rs1 is interpreted as two's complement for these ops
  function automatic logic is_signed_a(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement for these ops (MULHSU keeps rs2 unsigned)
  function automatic logic is_signed_b(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input mdu_op_t op);
    return op[2];
  endfunction

  // Within the divide family, funct3[1] selects the remainder
  function automatic logic is_rem_op(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: execute-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            startE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            busyE;
  logic            doneE;
  logic [XLEN-1:0] ResultE;

  modport master (
    output startE, funct3E, SrcAE, SrcBE, FlushE,
    input  busyE, doneE, ResultE
  );

  modport slave (
    input  startE, funct3E, SrcAE, SrcBE, FlushE,
    output busyE, doneE, ResultE
  );

endinterface

// File: rtl/mdu_divstep.sv
// mdu_divstep: one restoring-divide iteration producing a single quotient bit.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dividendBit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qBit
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  // Shift the next dividend bit in, trial-subtract, keep the difference only if it stayed non-negative
  always_comb begin
    w_shifted = {i_rem, i_dividendBit};
    w_diff    = w_shifted - {1'b0, i_divisor};
    o_qBit    = ~w_diff[XLEN];
    o_rem     = o_qBit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit (shift-add multiply, restoring divide) for the execute stage.
// Optional feature macro MDU_FAST_MUL_EN: multiplies use one combinational product and finish in one edge.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        r_state;
  mdu_state_t        w_nextState;
  mdu_op_t           r_op;
  logic              r_signA;
  logic              r_signB;
  logic [XLEN-1:0]   r_operand;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_result;

  mdu_op_t           w_op;
  logic              w_start;
  logic              w_signA;
  logic              w_signB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic              w_divZero;
  logic              w_overflow;
  logic              w_special;
  logic [XLEN-1:0]   w_specialResult;

  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [XLEN-1:0]   w_divRem;
  logic              w_qBit;
  logic [2*XLEN-1:0] w_divNext;

  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixResult;

  // A start is only taken when idle or just finished, and a flush in the same cycle cancels it
  assign w_start = ((r_state == IDLE) || (r_state == DONE)) && bus.startE && !bus.FlushE;

  // Decode the incoming op and turn signed operands into magnitudes
  always_comb begin
    w_op       = mdu_op_t'(bus.funct3E);
    w_signA    = is_signed_a(w_op) & bus.SrcAE[XLEN-1];
    w_signB    = is_signed_b(w_op) & bus.SrcBE[XLEN-1];
    w_magA     = w_signA ? -bus.SrcAE : bus.SrcAE;
    w_magB     = w_signB ? -bus.SrcBE : bus.SrcBE;
    w_divZero  = is_div_op(w_op) && (bus.SrcBE == '0);
    w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (bus.SrcAE == MIN_NEG) && (&bus.SrcBE);
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fastMag;
  logic [2*XLEN-1:0] w_fastProd;

  // Single-cycle product of the magnitudes, sign restored afterwards
  always_comb begin
    w_fastMag  = {{XLEN{1'b0}}, w_magA} * {{XLEN{1'b0}}, w_magB};
    w_fastProd = (w_signA ^ w_signB) ? -w_fastMag : w_fastMag;
  end
`endif

  // Ops whose result is known at start bypass the iteration and land in DONE directly
  always_comb begin
    w_special       = 1'b0;
    w_specialResult = '0;
    if (w_divZero) begin
      w_special       = 1'b1;
      w_specialResult = is_rem_op(w_op) ? bus.SrcAE : '1;
    end else if (w_overflow) begin
      w_special       = 1'b1;
      w_specialResult = is_rem_op(w_op) ? '0 : bus.SrcAE;
    end
`ifdef MDU_FAST_MUL_EN
    else if (!is_div_op(w_op)) begin
      w_special       = 1'b1;
      w_specialResult = (w_op == OP_MUL) ? w_fastProd[XLEN-1:0] : w_fastProd[2*XLEN-1:XLEN];
    end
`endif
  end

  // Shift-add multiply step: conditionally add the multiplicand to the upper half, then shift right
  always_comb begin
    w_addend  = r_acc[0] ? r_operand : '0;
    w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};
  end

  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .i_rem         (r_acc[2*XLEN-1:XLEN]),
    .i_dividendBit (r_acc[XLEN-1]),
    .i_divisor     (r_operand),
    .o_rem         (w_divRem),
    .o_qBit        (w_qBit)
  );

  // Divide keeps the partial remainder high and shifts quotient bits in as the dividend shifts out
  assign w_divNext = {w_divRem, r_acc[XLEN-2:0], w_qBit};

  // Restore signs and pick the architectural result from the accumulator
  always_comb begin
    w_product   = (r_signA ^ r_signB) ? -r_acc : r_acc;
    w_quot      = (r_signA ^ r_signB) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem       = r_signA ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fixResult = w_rem;
    case (r_op)
      OP_MUL:                        w_fixResult = w_product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fixResult = w_product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fixResult = w_quot;
      default:                       w_fixResult = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; a flush overrides everything and returns to IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start) w_nextState = w_special ? DONE : RUN;
        else         w_nextState = IDLE;
      end
      RUN:     if (r_count == CW'(XLEN-1)) w_nextState = FIX;
      FIX:     w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
    if (bus.FlushE) w_nextState = IDLE;
  end

  // Datapath registers: latch operands at start, iterate in RUN, commit the result entering DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= OP_MUL;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_operand <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_result  <= '0;
    end else if (w_start) begin
      r_op    <= w_op;
      r_signA <= w_signA;
      r_signB <= w_signB;
      r_count <= '0;
      if (is_div_op(w_op)) begin
        r_operand <= w_magB;
        r_acc     <= {{XLEN{1'b0}}, w_magA};
      end else begin
        r_operand <= w_magA;
        r_acc     <= {{XLEN{1'b0}}, w_magB};
      end
      if (w_special) r_result <= w_specialResult;
    end else if ((r_state == RUN) && !bus.FlushE) begin
      r_acc   <= is_div_op(r_op) ? w_divNext : w_mulNext;
      r_count <= r_count + CW'(1);
    end else if ((r_state == FIX) && !bus.FlushE) begin
      r_result <= w_fixResult;
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.busyE   = (r_state == RUN) || (r_state == FIX);
    bus.doneE   = (r_state == DONE);
    bus.ResultE = r_result;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu (XLEN = 32), table vectors plus scoreboard of results.
module tb_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int MAX_WAIT = 200;

  typedef struct {
    string       name;
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic        clk;
  logic        reset;
  int          tests = 0;
  int          failures = 0;
  logic [31:0] lastExpected = '0;
  exp_t        expQ[$];
  vec_t        vecs[15];

  mdu_if #(.XLEN(XLEN)) bus ();

  mdu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference behaviour of the RV32M ops using wide native arithmetic
  function automatic logic [31:0] modelResult(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sbu;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sbu = longint'(ub);
    t   = '0;
    case (op)
      OP_MUL:    begin t = ua * ub;  return t[31:0];  end
      OP_MULH:   begin t = sa * sb;  return t[63:32]; end
      OP_MULHSU: begin t = sa * sbu; return t[63:32]; end
      OP_MULHU:  begin t = ua * ub;  return t[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        t = sa / sb;
        return t[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        t = sa % sb;
        return t[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the start cycle to the doneE cycle
  function automatic int expLatency(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0)) return 1;
    if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Scoreboard consumer: every doneE pulse pops and compares the oldest expected result
  always @(posedge clk) begin
    #1;
    if (bus.doneE === 1'b1) begin
      if (expQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_done: got doneE=1 ResultE=%h, expected no doneE", bus.ResultE);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        lastExpected = e.value;
        checkOutput(e.name, bus.ResultE, e.value);
      end
    end
  end

  // Push the expected result and present a one-cycle start; returns #1 after the sampling edge
  task automatic applyStimulus(input string name, input mdu_op_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expValue, input bit now);
    exp_t e;
    e.name  = name;
    e.value = expValue;
    expQ.push_back(e);
    if (!now) @(negedge clk);
    bus.funct3E = op;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.startE  = 1'b1;
    @(posedge clk);
    #1;
    bus.startE  = 1'b0;
  endtask

  // Wait for doneE, counting cycles from the start cycle and cycles with busyE high
  task automatic waitDone(input string name, output int lat, output int busyCnt);
    lat     = 1;
    busyCnt = 0;
    while ((bus.doneE !== 1'b1) && (lat < MAX_WAIT)) begin
      if (bus.busyE === 1'b1) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.doneE !== 1'b1) begin
      tests++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no doneE, expected doneE within %0d cycles", name, MAX_WAIT);
    end
  endtask

  task automatic runOp(input string name, input mdu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expValue);
    int lat;
    int busyCnt;
    int el;
    el = expLatency(op, a, b);
    applyStimulus(name, op, a, b, expValue, 1'b0);
    waitDone(name, lat, busyCnt);
    checkOutput({name, "_latency"}, 32'(lat), 32'(el));
    checkOutput({name, "_busy_cycles"}, 32'(busyCnt), (el == 1) ? 32'd0 : 32'(XLEN + 1));
  endtask

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat1;
    int lat2;
    int busyCnt;
    mdu_op_t     rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{"mul_7_x_neg3",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"mulhu_max",        OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{"mulhsu_neg1_x_2",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[3]  = '{"mulh_min_x_min",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{"div_neg7_by_2",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{"rem_neg7_by_2",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{"divu_100_by_7",    OP_DIVU,   32'd100,        32'd7,         32'd14};
    vecs[7]  = '{"remu_100_by_7",    OP_REMU,   32'd100,        32'd7,         32'd2};
    vecs[8]  = '{"div_7_by_neg2",    OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[9]  = '{"rem_7_by_neg2",    OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
    vecs[10] = '{"divu_5_by_0",      OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{"remu_5_by_0",      OP_REMU,   32'd5,          32'd0,         32'd5};
    vecs[12] = '{"div_overflow",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{"rem_overflow",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[14] = '{"mul_zero",         OP_MUL,    32'd0,          32'h1234_5678, 32'd0};

    reset       = 1'b0;
    bus.startE  = 1'b0;
    bus.FlushE  = 1'b0;
    bus.funct3E = 3'b000;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",   {31'b0, bus.busyE}, 32'd0);
    checkOutput("reset_done",   {31'b0, bus.doneE}, 32'd0);
    checkOutput("reset_result", bus.ResultE,        32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expResult);

    for (int i = 0; i < 10; i++) begin
      rop = mdu_op_t'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, modelResult(rop, ra, rb));
    end

    // Flush partway through a divide: no done, result held
    @(negedge clk);
    bus.funct3E = OP_DIV;
    bus.SrcAE   = 32'd1000;
    bus.SrcBE   = 32'd7;
    bus.startE  = 1'b1;
    @(negedge clk);
    bus.startE  = 1'b0;
    repeat (9) @(negedge clk);
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_busy",   {31'b0, bus.busyE}, 32'd0);
    checkOutput("flush_done",   {31'b0, bus.doneE}, 32'd0);
    checkOutput("flush_result", bus.ResultE,        lastExpected);
    @(negedge clk);
    bus.FlushE = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("flush_result_later", bus.ResultE, lastExpected);
    runOp("mul_3x4_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12);

    // Reset asserted mid-operation clears the outputs without waiting for a clock edge
    @(negedge clk);
    bus.funct3E = OP_DIVU;
    bus.SrcAE   = 32'd1000;
    bus.SrcBE   = 32'd3;
    bus.startE  = 1'b1;
    @(negedge clk);
    bus.startE  = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("midop_busy_before_reset", {31'b0, bus.busyE}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midop_reset_busy",   {31'b0, bus.busyE}, 32'd0);
    checkOutput("midop_reset_done",   {31'b0, bus.doneE}, 32'd0);
    checkOutput("midop_reset_result", bus.ResultE,        32'd0);
    @(negedge clk);
    reset = 1'b1;
    lastExpected = '0;

    // Back-to-back: second start presented in the DONE cycle of the first
    applyStimulus("b2b_divu_9_by_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);
    waitDone("b2b_divu_9_by_3", lat1, busyCnt);
    checkOutput("b2b_first_latency", 32'(lat1), 32'(XLEN + 2));
    applyStimulus("b2b_mul_5x6", OP_MUL, 32'd5, 32'd6, 32'd30, 1'b1);
    waitDone("b2b_mul_5x6", lat2, busyCnt);
    checkOutput("b2b_done_spacing", 32'(lat2), 32'(expLatency(OP_MUL, 32'd5, 32'd6)));

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
